// File: rtl/alu_pkg.sv
// ALU opcode encodings and RV major opcodes shared by the
// register-read to execute boundary.
package alu_pkg;

   typedef logic [3:0] alu_op_t;
   typedef logic [6:0] rv_opc_t;

   localparam alu_op_t ALU_ADD  = 4'b0000;
   localparam alu_op_t ALU_SUB  = 4'b0001;
   localparam alu_op_t ALU_SLL  = 4'b0010;
   localparam alu_op_t ALU_SLT  = 4'b0100;
   localparam alu_op_t ALU_SLTU = 4'b0110;
   localparam alu_op_t ALU_XOR  = 4'b1000;
   localparam alu_op_t ALU_SRL  = 4'b1010;
   localparam alu_op_t ALU_SRA  = 4'b1011;
   localparam alu_op_t ALU_OR   = 4'b1100;
   localparam alu_op_t ALU_AND  = 4'b1110;

   localparam rv_opc_t OPC_OP    = 7'b0110011;
   localparam rv_opc_t OPC_OPIMM = 7'b0010011;
   localparam rv_opc_t OPC_LUI   = 7'b0110111;
   localparam rv_opc_t OPC_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into
// ALU opcode and operands; anything else is flagged illegal.
module rv_alu_decode
   import alu_pkg::*;
#(
   parameter int width = 32
) (
   input  logic [31:0]      instr,
   input  logic [width-1:0] pc,
   input  logic [width-1:0] rs1,
   input  logic [width-1:0] rs2,
   output alu_op_t          opcode,
   output logic [width-1:0] a,
   output logic [width-1:0] b,
   output logic [4:0]       rd,
   output logic             illegal
);

   localparam int SHW = $clog2(width);
   // Bits above the shamt field that must be zero for shifts
   localparam logic [31:0] SH_HI =
      ~((32'd1 << (20 + SHW)) - 32'd1);
   localparam logic [31:0] BIT30 = 32'h4000_0000;

   rv_opc_t          opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [SHW-1:0]   shamt;
   logic [width-1:0] imm_i;
   logic [width-1:0] imm_u;
   logic             is_op;
   logic             is_opimm;
   logic             op_leg;
   logic             sll_leg;
   logic             sr_leg;
   logic             imm_leg;
   logic             lui_leg;
   logic             auipc_leg;
   logic             unused_rs1f;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign rd    = instr[11:7];
   assign shamt = instr[20 +: SHW];
   assign imm_i = width'($signed(instr[31:20]));
   assign imm_u = width'($signed({instr[31:12], 12'b0}));

   assign unused_rs1f = ^instr[19:15];

   assign is_op    = (opc == OPC_OP);
   assign is_opimm = (opc == OPC_OPIMM);

   assign op_leg = is_op &
      ((f7 == F7_BASE) |
       ((f7 == F7_ALT) & ((f3 == F3_ADD) | (f3 == F3_SR))));

   assign sll_leg = is_opimm & (f3 == F3_SLL) &
      ((instr & SH_HI) == 32'd0);
   assign sr_leg = is_opimm & (f3 == F3_SR) &
      ((instr & SH_HI & ~BIT30) == 32'd0);
   assign imm_leg = is_opimm &
      (f3 != F3_SLL) & (f3 != F3_SR);

   assign lui_leg   = (opc == OPC_LUI);
   assign auipc_leg = (opc == OPC_AUIPC);

   always_comb begin
      opcode  = ALU_ADD;
      a       = '0;
      b       = '0;
      illegal = 1'b1;
      unique case (1'b1)
         op_leg: begin
            opcode  = {f3, instr[30]};
            a       = rs1;
            b       = rs2;
            illegal = 1'b0;
         end
         sll_leg: begin
            opcode  = ALU_SLL;
            a       = rs1;
            b       = width'(shamt);
            illegal = 1'b0;
         end
         sr_leg: begin
            opcode  = {F3_SR, instr[30]};
            a       = rs1;
            b       = width'(shamt);
            illegal = 1'b0;
         end
         // Immediate forms never take instr[30], so ADDI stays ADD
         imm_leg: begin
            opcode  = {f3, 1'b0};
            a       = rs1;
            b       = imm_i;
            illegal = 1'b0;
         end
         lui_leg: begin
            b       = imm_u;
            illegal = 1'b0;
         end
         auipc_leg: begin
            a       = pc;
            b       = imm_u;
            illegal = 1'b0;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue decoder: decode plus main/skid output registers
// behind a valid/ready handshake with registered in_ready.
module alu_issue_decoder
   import alu_pkg::*;
#(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [width-1:0] in_pc,
   input  logic [width-1:0] in_rs1,
   input  logic [width-1:0] in_rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_opcode,
   output logic [width-1:0] out_A,
   output logic [width-1:0] out_B,
   output logic [4:0]       out_rd,
   output logic             out_illegal
);

   typedef struct packed {
      alu_op_t          op;
      logic [width-1:0] a;
      logic [width-1:0] b;
      logic [4:0]       rd;
      logic             ill;
   } uop_t;

   uop_t dec;
   uop_t main_q, main_d;
   uop_t skid_q, skid_d;
   logic main_valid_q, main_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic in_ready_q, in_ready_d;
   logic in_fire;
   logic out_fire;

   rv_alu_decode #(.width(width)) u_dec (
      .instr   (in_instr),
      .pc      (in_pc),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .opcode  (dec.op),
      .a       (dec.a),
      .b       (dec.b),
      .rd      (dec.rd),
      .illegal (dec.ill)
   );

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = main_valid_q & out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire | ~main_valid_q) begin
         // Skid full implies in_ready low, so no input competes
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) main_d = dec;
         end
      end else if (in_fire) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign out_opcode  = main_q.op;
   assign out_A       = main_q.a;
   assign out_B       = main_q.b;
   assign out_rd      = main_q.rd;
   assign out_illegal = main_q.ill;

endmodule
